gf_int_multiplier_bank: RTL and testbench

- Dual-mode unsigned multiplier bank for comparing multiplier architectures.
- Four independent DATA_WIDTH x DATA_WIDTH multipliers, each built with a different architecture, share operands a and b.
- gf_option selects the mode:
  - 0: ordinary integer product.
  - 1: carry-less GF(2)[x] polynomial product, unreduced.
- All four outputs are registered and must always agree; the block is a cross-check and area/timing comparison vehicle.

---
 rtl/gf_int_multiplier_bank.sv | 123 ++++++++++++
 tb/tb_gf_int_multiplier_bank.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/gf_int_multiplier_bank.sv
// Four-architecture unsigned multiplier bank with integer / carry-less (GF(2)[x]) mode.
// Reference, array, carry-save and Karatsuba products are computed in parallel and registered.
module gf_int_multiplier_bank #(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      gf_option,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic [2*DATA_WIDTH-1:0]   out,
  output logic [2*DATA_WIDTH-1:0]   out2,
  output logic [2*DATA_WIDTH-1:0]   out3,
  output logic [2*DATA_WIDTH-1:0]   out4
);

  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned H  = DATA_WIDTH / 2;
  localparam int unsigned HW = H + 1;

  // Carry-less product of two DATA_WIDTH-bit polynomials.
  function automatic logic [PW-1:0] clmul(input logic [DATA_WIDTH-1:0] x,
                                          input logic [DATA_WIDTH-1:0] y);
    logic [PW-1:0] acc;
    acc = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      if (y[i]) acc = acc ^ (PW'(x) << i);
    end
    return acc;
  endfunction

  logic [PW-1:0] ref_res;
  logic [PW-1:0] arr_res, arr_pp;
  logic [PW-1:0] csa_res, csa_pp, csa_s, csa_c, csa_t, csa_nc;
  logic [PW-1:0] kar_res;
  logic [PW-1:0] k_lo, k_hi, k_mid, g_lo, g_hi, g_mid;
  logic [H-1:0]  a0, a1, b0, b1;
  logic [HW-1:0] as_s, bs_s;

  always_comb begin
    ref_res = gf_option ? clmul(a, b) : PW'(a) * PW'(b);
  end

  // Array: accumulate shifted partial products one row at a time.
  always_comb begin
    arr_res = '0;
    arr_pp  = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      arr_pp  = b[i] ? (PW'(a) << i) : '0;
      arr_res = gf_option ? (arr_res ^ arr_pp) : (arr_res + arr_pp);
    end
  end

  // Carry-save: keep a redundant sum/carry pair, resolve with one final adder.
  always_comb begin
    csa_s  = b[0] ? PW'(a) : '0;
    csa_c  = '0;
    csa_pp = '0;
    csa_t  = '0;
    csa_nc = '0;
    for (int i = 1; i < int'(DATA_WIDTH); i++) begin
      csa_pp = b[i] ? (PW'(a) << i) : '0;
      csa_t  = csa_s ^ csa_c ^ csa_pp;
      csa_nc = gf_option ? '0
             : (((csa_s & csa_c) | (csa_s & csa_pp) | (csa_c & csa_pp)) << 1);
      csa_s  = csa_t;
      csa_c  = csa_nc;
    end
    csa_res = gf_option ? (csa_s ^ csa_c) : (csa_s + csa_c);
  end

  assign a0 = a[H-1:0];
  assign a1 = a[DATA_WIDTH-1:H];
  assign b0 = b[H-1:0];
  assign b1 = b[DATA_WIDTH-1:H];

  // Karatsuba: three half-width sub-products; mid operands need one extra bit for the sum.
  always_comb begin
    as_s  = gf_option ? HW'(a0 ^ a1) : (HW'(a0) + HW'(a1));
    bs_s  = gf_option ? HW'(b0 ^ b1) : (HW'(b0) + HW'(b1));
    k_lo  = PW'(a0) * PW'(b0);
    k_hi  = PW'(a1) * PW'(b1);
    k_mid = PW'(as_s) * PW'(bs_s) - k_hi - k_lo;
    g_lo  = clmul(DATA_WIDTH'(a0), DATA_WIDTH'(b0));
    g_hi  = clmul(DATA_WIDTH'(a1), DATA_WIDTH'(b1));
    g_mid = clmul(DATA_WIDTH'(as_s), DATA_WIDTH'(bs_s)) ^ g_hi ^ g_lo;
    if (gf_option) begin
      kar_res = (g_hi << (2 * H)) ^ (g_mid << H) ^ g_lo;
    end else begin
      kar_res = (k_hi << (2 * H)) + (k_mid << H) + k_lo;
    end
  end

  logic [PW-1:0] out_d, out2_d, out3_d, out4_d;
  logic [PW-1:0] out_q, out2_q, out3_q, out4_q;

  always_comb begin
    out_d  = ref_res;
    out2_d = arr_res;
    out3_d = csa_res;
    out4_d = kar_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      out2_q <= '0;
      out3_q <= '0;
      out4_q <= '0;
    end else begin
      out_q  <= out_d;
      out2_q <= out2_d;
      out3_q <= out3_d;
      out4_q <= out4_d;
    end
  end

  assign out  = out_q;
  assign out2 = out2_q;
  assign out3 = out3_q;
  assign out4 = out4_q;

endmodule

// File: tb/tb_gf_int_multiplier_bank.sv
// Self-checking bench: DATA_WIDTH=4 and DATA_WIDTH=8 instances against an arithmetic model.
module tb_gf_int_multiplier_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        gf;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic [7:0]  o4_1, o4_2, o4_3, o4_4;
  logic [15:0] o8_1, o8_2, o8_3, o8_4;
  logic [7:0]  exp4;
  logic [15:0] exp8;
  int          checks = 0;
  int          failures = 0;
  bit          cmp_en = 1'b0;

  gf_int_multiplier_bank #(.DATA_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .gf_option(gf), .a(a4), .b(b4),
    .out(o4_1), .out2(o4_2), .out3(o4_3), .out4(o4_4)
  );

  gf_int_multiplier_bank #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .gf_option(gf), .a(a8), .b(b8),
    .out(o8_1), .out2(o8_2), .out3(o8_3), .out4(o8_4)
  );

  always #5 clk = ~clk;

  // Integer product or XOR-of-shifted-copies product.
  function automatic logic [63:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic g);
    logic [63:0] r;
    r = '0;
    if (!g) return x * y;
    for (int i = 0; i < 32; i++) begin
      if (y[i]) r = r ^ (x << i);
    end
    return r;
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, want, $time);
    end
  endtask

  // One-cycle-latency expectation from the inputs seen at each edge.
  always @(posedge clk) begin
    exp4 <= rst ? 8'h0  : 8'(model(64'(a4), 64'(b4), gf));
    exp8 <= rst ? 16'h0 : 16'(model(64'(a8), 64'(b8), gf));
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp("w4/out",  64'(o4_1), 64'(exp4));
      cmp("w4/out2", 64'(o4_2), 64'(exp4));
      cmp("w4/out3", 64'(o4_3), 64'(exp4));
      cmp("w4/out4", 64'(o4_4), 64'(exp4));
      cmp("w8/out",  64'(o8_1), 64'(exp8));
      cmp("w8/out2", 64'(o8_2), 64'(exp8));
      cmp("w8/out3", 64'(o8_3), 64'(exp8));
      cmp("w8/out4", 64'(o8_4), 64'(exp8));
    end
  end

  task automatic set_in(input logic [3:0] x, input logic [3:0] y, input logic g);
    a4 = x;
    b4 = y;
    gf = g;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
  endtask

  // Wait one edge, then check all four narrow outputs against a literal.
  task automatic after_edge(input string nm, input logic [7:0] val);
    @(posedge clk);
    #1;
    cmp({nm, "/out"},  64'(o4_1), 64'(val));
    cmp({nm, "/out2"}, 64'(o4_2), 64'(val));
    cmp({nm, "/out3"}, 64'(o4_3), 64'(val));
    cmp({nm, "/out4"}, 64'(o4_4), 64'(val));
  endtask

  initial begin
    rst = 1'b1;
    gf  = 1'b0;
    a4  = 4'd15;
    b4  = 4'd13;
    a8  = 8'd0;
    b8  = 8'd0;

    cmp("model_int_12x10", model(64'd12, 64'd10, 1'b0), 64'd120);
    cmp("model_gf_15x13",  model(64'd15, 64'd13, 1'b1), 64'd75);
    cmp("model_gf_15x15",  model(64'd15, 64'd15, 1'b1), 64'd85);
    cmp("model_int_ff_ff", model(64'd255, 64'd255, 1'b0), 64'd65025);

    @(posedge clk);
    #1;
    cmp_en = 1'b1;
    after_edge("rst_a", 8'd0);
    after_edge("rst_b", 8'd0);
    rst = 1'b0;
    after_edge("rst_release", 8'd195);

    set_in(4'd12, 4'd10, 1'b0); after_edge("int_12x10", 8'd120);
    set_in(4'd5,  4'd9,  1'b0); after_edge("int_5x9",   8'd45);
    set_in(4'd15, 4'd13, 1'b0); after_edge("int_15x13", 8'd195);
    set_in(4'd15, 4'd13, 1'b1); after_edge("gf_15x13",  8'd75);
    set_in(4'd12, 4'd10, 1'b1); after_edge("gf_12x10",  8'd120);
    set_in(4'd5,  4'd9,  1'b1); after_edge("gf_5x9",    8'd45);
    set_in(4'd15, 4'd15, 1'b1); after_edge("gf_15x15",  8'd85);

    set_in(4'd15, 4'd13, 1'b0); after_edge("toggle0", 8'd195);
    set_in(4'd15, 4'd13, 1'b1); after_edge("toggle1", 8'd75);
    set_in(4'd15, 4'd13, 1'b0); after_edge("toggle2", 8'd195);

    set_in(4'd0,  4'd13, 1'b0); after_edge("int_zero_a", 8'd0);
    set_in(4'd0,  4'd13, 1'b1); after_edge("gf_zero_a",  8'd0);
    set_in(4'd11, 4'd0,  1'b1); after_edge("gf_zero_b",  8'd0);
    set_in(4'd1,  4'd9,  1'b0); after_edge("int_one_a",  8'd9);
    set_in(4'd1,  4'd9,  1'b1); after_edge("gf_one_a",   8'd9);
    set_in(4'd13, 4'd1,  1'b1); after_edge("gf_one_b",   8'd13);
    set_in(4'd15, 4'd15, 1'b0); after_edge("int_max",    8'd225);

    // Exhaustive narrow sweep; the wide instance sees random operands alongside.
    for (int g = 0; g < 2; g++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          @(posedge clk);
          #1;
          set_in(4'(x), 4'(y), 1'(g));
        end
      end
    end

    // Random mix including occasional mid-stream resets and wide corner operands.
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      set_in(4'($urandom), 4'($urandom), 1'($urandom));
      rst = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) begin
        a8 = 8'hFF;
        b8 = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'h01;
      end
    end

    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
